// File: rtl/disp_hazard_ctrl_pkg.sv
// Shared types for the dispatch hazard controller.
// FSM encodings, OITF entry layout and a register-match helper.
package disp_hazard_ctrl_pkg;

  localparam int REGADDR_W = 5;

  typedef enum logic [1:0] {
    DISP_ST_RUN   = 2'd0,
    DISP_ST_FLUSH = 2'd1,
    DISP_ST_SWAIT = 2'd2
  } disp_st_e;

  typedef struct packed {
    logic                 vld;
    logic                 rdwen;
    logic [REGADDR_W-1:0] rdidx;
  } oitf_ent_t;

  function automatic logic reg_match(
    input logic                 en,
    input logic [REGADDR_W-1:0] a,
    input logic [REGADDR_W-1:0] b
  );
    return en && (a == b);
  endfunction

endpackage

// File: rtl/disp_hazard_ctrl_oitf.sv
// Outstanding long-instruction table: in-order FIFO of long ops.
// Count is kept apart from the pointers so full and empty differ.
module disp_oitf
  import disp_hazard_ctrl_pkg::*;
#(
  parameter int OITF_DEPTH = 2,
  parameter int PTR_W      = $clog2(OITF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc,
  input  logic                  alloc_rdwen,
  input  logic [REGADDR_W-1:0]  alloc_rdidx,
  input  logic                  ret,
  input  logic                  rs1en,
  input  logic [REGADDR_W-1:0]  rs1_idx,
  input  logic                  rs2en,
  input  logic [REGADDR_W-1:0]  rs2_idx,
  input  logic                  rdwen,
  input  logic [REGADDR_W-1:0]  rdidx,
  output logic [PTR_W-1:0]      wptr,
  output logic                  empty,
  output logic                  full,
  output logic                  ret_rdwen,
  output logic [REGADDR_W-1:0]  ret_rdidx,
  output logic [OITF_DEPTH-1:0] hit
);

  oitf_ent_t        ent [OITF_DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PTR_W+1)'(OITF_DEPTH));
  assign pop   = ret && !empty;
  assign wptr  = wptr_q;

  assign ret_rdwen = !empty && ent[rptr_q].rdwen;
  assign ret_rdidx = empty ? '0 : ent[rptr_q].rdidx;

  // Per-entry RAW/WAW match; x0 never hazards.
  always_comb begin
    hit = '0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      hit[i] = ent[i].vld && ent[i].rdwen &&
               (ent[i].rdidx != '0) &&
               (reg_match(rs1en, rs1_idx, ent[i].rdidx) ||
                reg_match(rs2en, rs2_idx, ent[i].rdidx) ||
                reg_match(rdwen, rdidx, ent[i].rdidx));
    end
  end

  // Allocate at tail, free at head, track occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < OITF_DEPTH; i++)
        ent[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (alloc) begin
        ent[wptr_q] <= '{vld: 1'b1,
                         rdwen: alloc_rdwen,
                         rdidx: alloc_rdidx};
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pop) begin
        ent[rptr_q].vld <= 1'b0;
        rptr_q <= rptr_q + PTR_W'(1);
      end
      if (alloc && !pop)
        cnt_q <= cnt_q + (PTR_W+1)'(1);
      else if (pop && !alloc)
        cnt_q <= cnt_q - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/disp_hazard_ctrl.sv
// Dispatch controller: gates decode handshake on OITF hazards,
// serialising ops and jump flushes; counts stalled cycles.
module disp_hazard_ctrl
  import disp_hazard_ctrl_pkg::*;
#(
  parameter int OITF_DEPTH = 2,
  parameter int PTR_W      = $clog2(OITF_DEPTH),
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_vld_i,
  output logic                 dec_rdy_o,
  input  logic                 dec_rs1en_i,
  input  logic                 dec_rs2en_i,
  input  logic [REGADDR_W-1:0] dec_rs1_idx_i,
  input  logic [REGADDR_W-1:0] dec_rs2_idx_i,
  input  logic                 dec_rdwen_i,
  input  logic [REGADDR_W-1:0] dec_rdidx_i,
  input  logic                 dec_long_i,
  input  logic                 dec_serial_i,
  output logic                 disp_vld_o,
  input  logic                 disp_rdy_i,
  output logic [PTR_W-1:0]     disp_itag_o,
  input  logic                 jump_flag_i,
  input  logic                 oitf_ret_i,
  output logic                 oitf_ret_rdwen_o,
  output logic [REGADDR_W-1:0] oitf_ret_rdidx_o,
  output logic                 oitf_empty_o,
  output logic                 oitf_full_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  disp_st_e              state;
  logic                  ok;
  logic                  hazard;
  logic                  alloc;
  logic [OITF_DEPTH-1:0] hit;

  assign hazard = |hit;

  assign ok = (state == DISP_ST_RUN) && !jump_flag_i && !hazard &&
              !(dec_long_i && oitf_full_o) &&
              !(dec_serial_i && !oitf_empty_o);

  assign disp_vld_o = dec_vld_i && ok;
  assign dec_rdy_o  = disp_rdy_i && ok;
  assign alloc      = disp_vld_o && disp_rdy_i && dec_long_i;

  disp_oitf #(
    .OITF_DEPTH(OITF_DEPTH),
    .PTR_W     (PTR_W)
  ) u_oitf (
    .clk        (clk),
    .rst        (rst),
    .alloc      (alloc),
    .alloc_rdwen(dec_rdwen_i),
    .alloc_rdidx(dec_rdidx_i),
    .ret        (oitf_ret_i),
    .rs1en      (dec_rs1en_i),
    .rs1_idx    (dec_rs1_idx_i),
    .rs2en      (dec_rs2en_i),
    .rs2_idx    (dec_rs2_idx_i),
    .rdwen      (dec_rdwen_i),
    .rdidx      (dec_rdidx_i),
    .wptr       (disp_itag_o),
    .empty      (oitf_empty_o),
    .full       (oitf_full_o),
    .ret_rdwen  (oitf_ret_rdwen_o),
    .ret_rdidx  (oitf_ret_rdidx_o),
    .hit        (hit)
  );

  // Dispatch FSM: one-cycle flush after jump, wait for drain on serial ops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DISP_ST_RUN;
    end else begin
      unique case (state)
        DISP_ST_RUN: begin
          if (jump_flag_i)
            state <= DISP_ST_FLUSH;
          else if (dec_vld_i && dec_serial_i && !oitf_empty_o)
            state <= DISP_ST_SWAIT;
        end
        DISP_ST_FLUSH:
          state <= DISP_ST_RUN;
        DISP_ST_SWAIT: begin
          if (jump_flag_i)
            state <= DISP_ST_FLUSH;
          else if (oitf_empty_o)
            state <= DISP_ST_RUN;
        end
        default:
          state <= DISP_ST_RUN;
      endcase
    end
  end

  // Saturating count of cycles the decoder is held off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_o <= '0;
    else if (dec_vld_i && !dec_rdy_o && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
  end

endmodule

// File: tb/tb_disp_hazard_ctrl.sv
// Directed bench for disp_hazard_ctrl.
// Inputs change 1ns after posedge; outputs sampled before next edge.
module tb_disp_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_vld_i;
  logic        dec_rdy_o;
  logic        dec_rs1en_i;
  logic        dec_rs2en_i;
  logic [4:0]  dec_rs1_idx_i;
  logic [4:0]  dec_rs2_idx_i;
  logic        dec_rdwen_i;
  logic [4:0]  dec_rdidx_i;
  logic        dec_long_i;
  logic        dec_serial_i;
  logic        disp_vld_o;
  logic        disp_rdy_i;
  logic [0:0]  disp_itag_o;
  logic        jump_flag_i;
  logic        oitf_ret_i;
  logic        oitf_ret_rdwen_o;
  logic [4:0]  oitf_ret_rdidx_o;
  logic        oitf_empty_o;
  logic        oitf_full_o;
  logic [15:0] stall_cnt_o;

  int n_pass = 0;
  int n_tot  = 0;

  disp_hazard_ctrl #(.OITF_DEPTH(2), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .dec_vld_i       (dec_vld_i),
    .dec_rdy_o       (dec_rdy_o),
    .dec_rs1en_i     (dec_rs1en_i),
    .dec_rs2en_i     (dec_rs2en_i),
    .dec_rs1_idx_i   (dec_rs1_idx_i),
    .dec_rs2_idx_i   (dec_rs2_idx_i),
    .dec_rdwen_i     (dec_rdwen_i),
    .dec_rdidx_i     (dec_rdidx_i),
    .dec_long_i      (dec_long_i),
    .dec_serial_i    (dec_serial_i),
    .disp_vld_o      (disp_vld_o),
    .disp_rdy_i      (disp_rdy_i),
    .disp_itag_o     (disp_itag_o),
    .jump_flag_i     (jump_flag_i),
    .oitf_ret_i      (oitf_ret_i),
    .oitf_ret_rdwen_o(oitf_ret_rdwen_o),
    .oitf_ret_rdidx_o(oitf_ret_rdidx_o),
    .oitf_empty_o    (oitf_empty_o),
    .oitf_full_o     (oitf_full_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_vld_i = 0; dec_rs1en_i = 0; dec_rs2en_i = 0;
    dec_rs1_idx_i = 0; dec_rs2_idx_i = 0;
    dec_rdwen_i = 0; dec_rdidx_i = 0;
    dec_long_i = 0; dec_serial_i = 0;
    jump_flag_i = 0; oitf_ret_i = 0; disp_rdy_i = 1;
  endtask

  task automatic op(input logic lng, input logic ser,
                    input logic wen, input logic [4:0] rd,
                    input logic r1en, input logic [4:0] r1);
    dec_vld_i = 1; dec_long_i = lng; dec_serial_i = ser;
    dec_rdwen_i = wen; dec_rdidx_i = rd;
    dec_rs1en_i = r1en; dec_rs1_idx_i = r1;
    dec_rs2en_i = 0; dec_rs2_idx_i = 0;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    step();
    step();
    rst = 1;
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_empty", oitf_empty_o, 1);
    chk("rst_full", oitf_full_o, 0);
    chk("rst_itag", disp_itag_o, 0);
    chk("rst_rdwen", oitf_ret_rdwen_o, 0);
    chk("rst_rdidx", oitf_ret_rdidx_o, 0);
    chk("rst_stall", stall_cnt_o, 0);
    chk("rst_rdy", dec_rdy_o, 1);

    // 1: RAW on x5 held until retire
    op(1, 0, 1, 5, 0, 0);
    chk("t1_vld", disp_vld_o, 1);
    chk("t1_itag", disp_itag_o, 0);
    step();
    op(0, 0, 1, 6, 1, 5);
    chk("t1_raw_rdy", dec_rdy_o, 0);
    chk("t1_raw_vld", disp_vld_o, 0);
    chk("t1_head_rd", oitf_ret_rdidx_o, 5);
    chk("t1_head_wen", oitf_ret_rdwen_o, 1);
    step();
    chk("t1_stall1", stall_cnt_o, 1);
    oitf_ret_i = 1; #1;
    chk("t1_ret_rdy", dec_rdy_o, 0);
    step();
    oitf_ret_i = 0; #1;
    chk("t1_stall2", stall_cnt_o, 2);
    chk("t1_empty", oitf_empty_o, 1);
    chk("t1_go", disp_vld_o, 1);
    step();
    idle(); #1;
    chk("t1_stall_hold", stall_cnt_o, 2);

    // 2: fill DEPTH=2, third stalls, retire lets it in wrapped
    do_reset();
    op(1, 0, 1, 7, 0, 0);
    chk("t2_a_itag", disp_itag_o, 0);
    step();
    op(1, 0, 1, 8, 0, 0);
    chk("t2_b_rdy", dec_rdy_o, 1);
    chk("t2_b_itag", disp_itag_o, 1);
    step();
    op(1, 0, 1, 9, 0, 0);
    chk("t2_full", oitf_full_o, 1);
    chk("t2_c_rdy", dec_rdy_o, 0);
    step();
    chk("t2_c_vld", disp_vld_o, 0);
    oitf_ret_i = 1; #1;
    chk("t2_ret_blk", dec_rdy_o, 0);
    step();
    oitf_ret_i = 0; #1;
    chk("t2_c_go", dec_rdy_o, 1);
    chk("t2_c_itag", disp_itag_o, 0);
    chk("t2_head", oitf_ret_rdidx_o, 8);
    step();
    // 3: full, same-cycle retire and long op
    op(1, 0, 1, 10, 0, 0);
    oitf_ret_i = 1; #1;
    chk("t3_full", oitf_full_o, 1);
    chk("t3_blk", disp_vld_o, 0);
    step();
    oitf_ret_i = 0; #1;
    chk("t3_cnt1", oitf_full_o, 0);
    chk("t3_nempty", oitf_empty_o, 0);
    chk("t3_go", disp_vld_o, 1);
    chk("t3_itag", disp_itag_o, 1);
    step();
    idle(); #1;
    chk("t3_cnt2", oitf_full_o, 1);
    chk("t3_head", oitf_ret_rdidx_o, 9);

    // 4: jump with one entry outstanding
    do_reset();
    op(1, 0, 1, 5, 0, 0);
    step();
    op(0, 0, 1, 6, 0, 0);
    jump_flag_i = 1; #1;
    chk("t4_jmp_vld", disp_vld_o, 0);
    step();
    jump_flag_i = 0; #1;
    chk("t4_flush_vld", disp_vld_o, 0);
    chk("t4_flush_ne", oitf_empty_o, 0);
    step();
    op(0, 0, 1, 5, 0, 0);
    chk("t4_waw", dec_rdy_o, 0);
    op(0, 0, 1, 6, 0, 0);
    chk("t4_run_vld", disp_vld_o, 1);
    chk("t4_kept", oitf_empty_o, 0);
    step();
    idle();
    oitf_ret_i = 1;
    step();
    oitf_ret_i = 0; #1;
    chk("t4_retired", oitf_empty_o, 1);

    // 5: serial op waits for drain; x0 never hazards
    do_reset();
    op(1, 0, 1, 3, 0, 0);
    step();
    op(1, 0, 1, 4, 0, 0);
    step();
    op(0, 1, 0, 0, 0, 0);
    chk("t5_ser_rdy", dec_rdy_o, 0);
    step();
    chk("t5_stall1", stall_cnt_o, 1);
    step();
    chk("t5_stall2", stall_cnt_o, 2);
    oitf_ret_i = 1;
    step();
    step();
    oitf_ret_i = 0; #1;
    chk("t5_empty", oitf_empty_o, 1);
    chk("t5_swait", dec_rdy_o, 0);
    chk("t5_stall4", stall_cnt_o, 4);
    step();
    chk("t5_go", dec_rdy_o, 1);
    chk("t5_stall5", stall_cnt_o, 5);
    step();
    op(1, 0, 1, 0, 0, 0);
    chk("t5_x0_go", disp_vld_o, 1);
    step();
    op(0, 0, 0, 0, 1, 0);
    chk("t5_x0_rd", dec_rdy_o, 1);
    chk("t5_x0_ne", oitf_empty_o, 0);
    chk("t5_stall_h", stall_cnt_o, 5);
    step();

    // 6: async reset during SWAIT
    op(0, 1, 0, 0, 0, 0);
    step();
    step();
    chk("t6_stall", stall_cnt_o, 7);
    chk("t6_rdy0", dec_rdy_o, 0);
    #2 rst = 0;
    #1;
    chk("t6_empty", oitf_empty_o, 1);
    chk("t6_stall0", stall_cnt_o, 0);
    chk("t6_run", dec_rdy_o, 1);
    step();
    rst = 1;
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
